// File: rtl/logger_rec_packer.sv
// Serialises one timestamp record per handshake into an ASCII hex line,
// written one byte per cycle into the logger FIFO.
module logger_rec_packer #(
  parameter int         ID_W         = 16,
  parameter int         TS_W         = 64,
  parameter int         HEX_LOWER    = 0,
  parameter logic [7:0] DELIM        = 8'h2C,
  parameter int         DROP_ON_FULL = 0,
  parameter int         DROP_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic [ID_W-1:0]       ev_id,
  input  logic [TS_W-1:0]       ev_start,
  input  logic [TS_W-1:0]       ev_end,
  input  logic [TS_W-1:0]       ev_delta,
  input  logic [2:0]            cfg_field_en,
  input  logic                  cfg_crlf,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_din,
  input  logic                  fifo_full,
  input  logic                  fifo_prog_full,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int         ID_NIB  = (ID_W + 3) / 4;
  localparam int         TS_NIB  = (TS_W + 3) / 4;
  localparam logic [3:0] ID_LAST = 4'(ID_NIB - 1);
  localparam logic [3:0] TS_LAST = 4'(TS_NIB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SEP, S_TS, S_TERM_CR, S_TERM_LF
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [1:0]            fsel_q, fsel_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [TS_W-1:0]       start_q, start_d;
  logic [TS_W-1:0]       end_q, end_d;
  logic [TS_W-1:0]       delta_q, delta_d;
  logic [2:0]            fen_q, fen_d;
  logic                  crlf_q, crlf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic        can_take;
  logic        take;
  logic        drop;
  logic [63:0] nib_src;
  logic [3:0]  nib;
  logic [2:0]  nf;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((HEX_LOWER != 0) ? 8'h61 : 8'h41) + {4'h0, n - 4'd10};
  endfunction

  // Returns {found, field} for the lowest enabled field at or above 'from'.
  function automatic logic [2:0] next_field(input logic [2:0] fen, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (fen[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign can_take = (state_q == S_IDLE) && !fifo_prog_full;
  assign ev_ready = (DROP_ON_FULL != 0) ? 1'b1 : can_take;
  assign take     = ev_valid && can_take;
  assign drop     = (DROP_ON_FULL != 0) && ev_valid && !can_take;
  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    case (fsel_q)
      2'd0:    nib_src = 64'(start_q);
      2'd1:    nib_src = 64'(end_q);
      default: nib_src = 64'(delta_q);
    endcase
    if (state_q != S_TS) nib_src = 64'(id_q);
    nib = nib_src[{idx_q, 2'b00} +: 4];
    nf  = next_field(fen_q, (state_q == S_TS) ? (3'(fsel_q) + 3'd1) : 3'd0);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fsel_d     = fsel_q;
    id_d       = id_q;
    start_d    = start_q;
    end_d      = end_q;
    delta_d    = delta_q;
    fen_d      = fen_q;
    crlf_d     = crlf_q;
    drop_cnt_d = drop_cnt_q;
    fifo_wr_en = 1'b0;
    fifo_din   = 8'h00;

    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_ID;
          idx_d   = ID_LAST;
          id_d    = ev_id;
          start_d = ev_start;
          end_d   = ev_end;
          delta_d = ev_delta;
          fen_d   = cfg_field_en;
          crlf_d  = cfg_crlf;
        end
      end
      S_ID, S_TS: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = hex_char(nib);
        if (!fifo_full) begin
          if (idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
          end else if (nf[2]) begin
            state_d = S_SEP;
            fsel_d  = nf[1:0];
          end else begin
            state_d = crlf_q ? S_TERM_CR : S_TERM_LF;
          end
        end
      end
      S_SEP: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = DELIM;
        if (!fifo_full) begin
          state_d = S_TS;
          idx_d   = TS_LAST;
        end
      end
      S_TERM_CR: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = 8'h0D;
        if (!fifo_full) state_d = S_TERM_LF;
      end
      S_TERM_LF: begin
        fifo_wr_en = !fifo_full;
        fifo_din   = 8'h0A;
        if (!fifo_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      fsel_q     <= 2'd0;
      id_q       <= '0;
      start_q    <= '0;
      end_q      <= '0;
      delta_q    <= '0;
      fen_q      <= 3'd0;
      crlf_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fsel_q     <= fsel_d;
      id_q       <= id_d;
      start_q    <= start_d;
      end_q      <= end_d;
      delta_q    <= delta_d;
      fen_q      <= fen_d;
      crlf_q     <= crlf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
